// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : CtrlSigEnums
//  Description : Shared decoded-control encodings for the RV32EC core:
//                ALU ops, PC modes, LSU access widths and LSU FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package CtrlSigEnums;

   // ALU operation select from the decoder
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;

   // Next-PC source select
   typedef enum logic [1:0] {
      PC_INC, PC_BRANCH, PC_JUMP, PC_TRAP
   } pc_mode_e;

   // LSU access width, CtrlLSU[1:0]
   localparam logic [1:0] LSN = 2'b00;
   localparam logic [1:0] LSW = 2'b01;
   localparam logic [1:0] LSH = 2'b10;
   localparam logic [1:0] LSB = 2'b11;

   // LSU state machine encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_aligner
//  Description : Pure combinational byte-lane logic for the LSU. Store side
//                replicates data across lanes and builds the byte strobes;
//                load side picks the addressed lane and extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_aligner
   import CtrlSigEnums::*;
(
   input  logic [1:0]  st_width,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_byte_en,
   output logic        st_misaligned,
   input  logic [1:0]  ld_width,
   input  logic [1:0]  ld_lane,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store steering: replicate the low bits so any lane the strobe picks is valid
   always_comb begin
      st_wdata      = st_data;
      st_byte_en    = 4'b0000;
      st_misaligned = 1'b0;
      case (st_width)
         LSW: begin
            st_byte_en    = 4'b1111;
            st_misaligned = (st_lane != 2'b00);
         end
         LSH: begin
            st_wdata      = {2{st_data[15:0]}};
            st_byte_en    = 4'b0011 << st_lane;
            st_misaligned = st_lane[0];
         end
         LSB: begin
            st_wdata   = {4{st_data[7:0]}};
            st_byte_en = 4'b0001 << st_lane;
         end
         default: ;
      endcase
   end

   // Load extraction: select the addressed lane, then sign- or zero-extend
   always_comb begin
      case (ld_lane)
         2'd0:    ld_byte = ld_rdata[7:0];
         2'd1:    ld_byte = ld_rdata[15:8];
         2'd2:    ld_byte = ld_rdata[23:16];
         default: ld_byte = ld_rdata[31:24];
      endcase
      ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_width)
         LSB:     ld_result = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
         LSH:     ld_result = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
         default: ld_result = ld_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Multi-cycle RV32EC load/store unit. Issues one word-aligned
//                bus transaction per request and returns extended load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import CtrlSigEnums::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic [3:0]        CtrlLSU,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       StoreData,
   output logic              Busy,
   output logic              Done,
   output logic [31:0]       LoadData,
   output logic              Fault,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWData,
   output logic [3:0]        MemByteEn,
   input  logic              MemGnt,
   input  logic              MemRValid,
   input  logic [31:0]       MemRData
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [3:0]        byte_en_q;
   logic [1:0]        width_q;
   logic [1:0]        lane_q;
   logic              unsigned_q;
   logic [31:0]       load_q;
   logic              fault_q;

   logic [31:0]       st_wdata;
   logic [3:0]        st_byte_en;
   logic              st_misaligned;
   logic [31:0]       ld_result;

   // Store side sees the live request; load side sees the latched access
   lsu_lane_aligner u_aligner (
      .st_width      (CtrlLSU[1:0]),
      .st_lane       (Address[1:0]),
      .st_data       (StoreData),
      .st_wdata      (st_wdata),
      .st_byte_en    (st_byte_en),
      .st_misaligned (st_misaligned),
      .ld_width      (width_q),
      .ld_lane       (lane_q),
      .ld_unsigned   (unsigned_q),
      .ld_rdata      (MemRData),
      .ld_result     (ld_result)
   );

   // Transaction FSM plus latched request and load result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         byte_en_q  <= 4'b0000;
         width_q    <= LSN;
         lane_q     <= 2'b00;
         unsigned_q <= 1'b0;
         load_q     <= '0;
         fault_q    <= 1'b0;
      end else begin
         fault_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start && (CtrlLSU[1:0] != LSN)) begin
                  if (st_misaligned) begin
                     fault_q <= 1'b1;
                  end else begin
                     addr_q     <= {Address[ADDR_W-1:2], 2'b00};
                     we_q       <= CtrlLSU[2];
                     wdata_q    <= st_wdata;
                     byte_en_q  <= st_byte_en;
                     width_q    <= CtrlLSU[1:0];
                     lane_q     <= Address[1:0];
                     unsigned_q <= CtrlLSU[3];
                     state      <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (MemGnt) begin
                  state <= we_q ? ST_DONE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (MemRValid) begin
                  load_q <= ld_result;
                  state  <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign Busy      = (state != ST_IDLE);
   assign Done      = (state == ST_DONE);
   assign MemReq    = (state == ST_REQ);
   assign Fault     = fault_q;
   assign LoadData  = load_q;
   assign MemWe     = we_q;
   assign MemAddr   = addr_q;
   assign MemWData  = wdata_q;
   assign MemByteEn = byte_en_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        Start;
   logic [3:0]  CtrlLSU;
   logic [31:0] Address;
   logic [31:0] StoreData;
   logic        Busy;
   logic        Done;
   logic [31:0] LoadData;
   logic        Fault;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [3:0]  MemByteEn;
   logic        MemGnt;
   logic        MemRValid;
   logic [31:0] MemRData;

   int tests;
   int fails;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Start     (Start),
      .CtrlLSU   (CtrlLSU),
      .Address   (Address),
      .StoreData (StoreData),
      .Busy      (Busy),
      .Done      (Done),
      .LoadData  (LoadData),
      .Fault     (Fault),
      .MemReq    (MemReq),
      .MemWe     (MemWe),
      .MemAddr   (MemAddr),
      .MemWData  (MemWData),
      .MemByteEn (MemByteEn),
      .MemGnt    (MemGnt),
      .MemRValid (MemRValid),
      .MemRData  (MemRData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Start = 1'b0; CtrlLSU = 4'h0; Address = '0; StoreData = '0;
      MemGnt = 1'b0; MemRValid = 1'b0; MemRData = '0;
      #3;
      tests++;
      if ({Busy, Done, Fault, MemReq, MemWe} !== 5'b0) begin
         fails++; $display("FAIL reset_ctrl got=%b exp=00000", {Busy, Done, Fault, MemReq, MemWe});
      end
      tests++;
      if ({MemByteEn, MemAddr, MemWData, LoadData} !== 100'h0) begin
         fails++; $display("FAIL reset_data got=%h exp=0", {MemByteEn, MemAddr, MemWData, LoadData});
      end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_word_store();
      CtrlLSU = 4'b0101; Address = 32'h0000_0104; StoreData = 32'hDEAD_BEEF;
      Start = 1'b1; MemGnt = 1'b1;
      tick(); // cycle 1
      Start = 1'b0;
      tests++;
      if ({MemReq, MemWe, Busy, Done} !== 4'b1110) begin
         fails++; $display("FAIL wst_c1_ctrl got=%b exp=1110", {MemReq, MemWe, Busy, Done});
      end
      tests++;
      if (MemAddr !== 32'h104 || MemByteEn !== 4'b1111 || MemWData !== 32'hDEAD_BEEF) begin
         fails++; $display("FAIL wst_bus got=%h/%b/%h exp=104/1111/deadbeef", MemAddr, MemByteEn, MemWData);
      end
      tick(); // cycle 2
      MemGnt = 1'b0;
      tests++;
      if ({Done, Busy, MemReq} !== 3'b110) begin
         fails++; $display("FAIL wst_done got=%b exp=110", {Done, Busy, MemReq});
      end
      tick(); // cycle 3
      tests++;
      if ({Done, Busy} !== 2'b00) begin
         fails++; $display("FAIL wst_idle got=%b exp=00", {Done, Busy});
      end
   endtask

   task automatic test_byte_load(input logic uns, input logic [31:0] exp);
      CtrlLSU = {uns, 1'b0, 2'b11}; Address = 32'h0000_0203;
      Start = 1'b1; MemGnt = 1'b1;
      tick(); // cycle 1
      Start = 1'b0;
      tests++;
      if ({MemReq, MemWe, MemAddr} !== {2'b10, 32'h200}) begin
         fails++; $display("FAIL bld_req got=%b%b/%h exp=10/200", MemReq, MemWe, MemAddr);
      end
      tick(); // cycle 2
      MemGnt = 1'b0; MemRValid = 1'b1; MemRData = 32'h80A5_5A11;
      tests++;
      if ({Busy, MemReq, Done} !== 3'b100) begin
         fails++; $display("FAIL bld_wait got=%b exp=100", {Busy, MemReq, Done});
      end
      tick(); // cycle 3
      MemRValid = 1'b0;
      tests++;
      if (Done !== 1'b1 || LoadData !== exp) begin
         fails++; $display("FAIL bld_data uns=%b got=%b/%h exp=1/%h", uns, Done, LoadData, exp);
      end
      tick();
   endtask

   task automatic test_half_store();
      CtrlLSU = 4'b0110; Address = 32'h0000_0012; StoreData = 32'h0000_ABCD;
      Start = 1'b1; MemGnt = 1'b1;
      tick(); // cycle 1
      Start = 1'b0;
      tests++;
      if (MemAddr !== 32'h10 || MemByteEn !== 4'b1100 || MemWData !== 32'hABCD_ABCD || MemWe !== 1'b1) begin
         fails++; $display("FAIL hst_bus got=%h/%b/%h/%b exp=10/1100/abcdabcd/1", MemAddr, MemByteEn, MemWData, MemWe);
      end
      tick(); // cycle 2
      MemGnt = 1'b0;
      tests++;
      if (Done !== 1'b1) begin
         fails++; $display("FAIL hst_done got=%b exp=1", Done);
      end
      tick();
      tests++;
      if (LoadData !== 32'h0000_0080) begin
         fails++; $display("FAIL hst_keep_load got=%h exp=00000080", LoadData);
      end
   endtask

   task automatic test_misaligned();
      CtrlLSU = 4'b0001; Address = 32'h0000_0021; Start = 1'b1;
      tick(); // cycle 1
      tests++;
      if ({Fault, MemReq, Busy} !== 3'b100) begin
         fails++; $display("FAIL mis_fault got=%b exp=100", {Fault, MemReq, Busy});
      end
      // back-to-back valid byte load at the same address
      CtrlLSU = 4'b0011;
      tick(); // cycle 2
      Start = 1'b0; MemGnt = 1'b1;
      tests++;
      if ({Fault, MemReq, Busy} !== 3'b011) begin
         fails++; $display("FAIL mis_b2b got=%b exp=011", {Fault, MemReq, Busy});
      end
      tick(); // WAIT
      MemGnt = 1'b0; MemRValid = 1'b1; MemRData = 32'h0000_7F00;
      tick(); // DONE
      MemRValid = 1'b0;
      tests++;
      if (Done !== 1'b1 || LoadData !== 32'h0000_007F) begin
         fails++; $display("FAIL mis_b2b_data got=%b/%h exp=1/0000007f", Done, LoadData);
      end
      tick();
   endtask

   task automatic test_delayed();
      CtrlLSU = 4'b0010; Address = 32'h0000_0002; Start = 1'b1;
      MemRData = 32'h8001_1234; MemGnt = 1'b0; MemRValid = 1'b0;
      tick(); // cycle 1
      for (int c = 1; c <= 8; c++) begin
         tests++;
         if (Busy !== (c <= 7) || Done !== (c == 7)) begin
            fails++; $display("FAIL dly_busy_done c=%0d got=%b%b exp=%b%b", c, Busy, Done, c <= 7, c == 7);
         end
         if (c <= 3) begin
            tests++;
            if ({MemReq, MemWe, MemByteEn, MemAddr} !== {2'b10, 4'b1100, 32'h0}) begin
               fails++; $display("FAIL dly_req c=%0d got=%b%b/%b/%h exp=10/1100/0", c, MemReq, MemWe, MemByteEn, MemAddr);
            end
         end else begin
            tests++;
            if (MemReq !== 1'b0) begin
               fails++; $display("FAIL dly_noreq c=%0d got=%b exp=0", c, MemReq);
            end
         end
         if (c == 7) begin
            tests++;
            if (LoadData !== 32'hFFFF_8001) begin
               fails++; $display("FAIL dly_data got=%h exp=ffff8001", LoadData);
            end
         end
         // stray issue attempts while busy, to a different address
         Start     = (c == 2 || c == 4 || c == 7);
         CtrlLSU   = Start ? 4'b0101 : 4'b0010;
         Address   = Start ? 32'h0000_0500 : 32'h0000_0002;
         MemGnt    = (c == 3);
         MemRValid = (c == 6);
         tick();
      end
      Start = 1'b0;
      tests++;
      if (Busy !== 1'b0 || MemAddr !== 32'h0) begin
         fails++; $display("FAIL dly_ignored got=%b/%h exp=0/0", Busy, MemAddr);
      end
   endtask

   task automatic test_reset_mid();
      CtrlLSU = 4'b0001; Address = 32'h0000_0040; Start = 1'b1; MemGnt = 1'b1;
      tick(); // cycle 1
      Start = 1'b0;
      tick(); // cycle 2, WAIT
      MemGnt = 1'b0;
      tests++;
      if ({Busy, MemReq} !== 2'b10) begin
         fails++; $display("FAIL rmid_wait got=%b exp=10", {Busy, MemReq});
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({Busy, MemReq, Done} !== 3'b000) begin
         fails++; $display("FAIL rmid_async got=%b exp=000", {Busy, MemReq, Done});
      end
      tick();
      rst_n = 1'b1; MemRValid = 1'b1; MemRData = 32'hFFFF_FFFF;
      tick();
      MemRValid = 1'b0;
      tests++;
      if ({Done, Busy, Fault, MemReq, MemWe} !== 5'b0 || LoadData !== 32'h0) begin
         fails++; $display("FAIL rmid_late got=%b/%h exp=00000/0", {Done, Busy, Fault, MemReq, MemWe}, LoadData);
      end
      tests++;
      if ({MemByteEn, MemAddr, MemWData} !== 68'h0) begin
         fails++; $display("FAIL rmid_bus got=%h exp=0", {MemByteEn, MemAddr, MemWData});
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_word_store();
      test_byte_load(1'b0, 32'hFFFF_FF80);
      test_byte_load(1'b1, 32'h0000_0080);
      test_half_store();
      test_misaligned();
      test_delayed();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
